// File: rtl/floor_request_queue.sv
// Elevator floor request queue: button sync/debounce, press latch,
// FCFS request FIFO and dispatch/travel/dwell/halt sequencing.
module floor_request_queue #(
    parameter int DB_COUNT    = 1000000,
    parameter int DB_W        = 20,
    parameter int ARRIVE_HOLD = 50000000,
    parameter int HOLD_W      = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn,
    input  logic [3:0] cur_floor,
    input  logic       emergency_stop,
    output logic [3:0] target,
    output logic [3:0] pending,
    output logic       busy,
    output logic [2:0] q_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISPATCH,
        S_TRAVEL,
        S_ARRIVED,
        S_HALT
    } state_e;

    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DB_COUNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ARRIVE_HOLD - 1);

    logic [3:0]        sync1_q, sync2_q, lvl_q;
    logic [DB_W-1:0]   cnt_q [4];
    logic [3:0]        latch_q, latch_d;
    logic [3:0]        pending_q, pending_d;
    logic [2:0]        count_q, count_d;
    logic [1:0]        fifo_q [4];
    logic [1:0]        wr_q, rd_q;
    state_e            state_q, ret_q;
    logic [3:0]        target_q;
    logic [HOLD_W-1:0] dwell_q;

    logic [3:0] press, avail, sel_oh;
    logic [1:0] sel_idx;
    logic       sel_vld, here_drop, push, pop, arrive;

    // Two-flop synchroniser on the raw buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: level follows only after DB_COUNT cycles of disagreement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == lvl_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_MAX) begin
                    cnt_q[i] <= '0;
                    lvl_q[i] <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Press pulse coincides with the debounced level about to rise
    always_comb begin
        press = '0;
        for (int i = 0; i < 4; i++) begin
            press[i] = sync2_q[i] & ~lvl_q[i] & (cnt_q[i] == DB_MAX);
        end
    end

    // Accept the lowest latched press, decide push/pop and next counts
    always_comb begin
        avail   = latch_q | press;
        sel_idx = '0;
        for (int i = 3; i >= 0; i--) begin
            if (avail[i]) sel_idx = 2'(i);
        end
        sel_vld   = |avail;
        sel_oh    = 4'b0001 << sel_idx;
        latch_d   = sel_vld ? (avail & ~sel_oh) : avail;
        here_drop = (state_q == S_IDLE) && (count_q == 3'd0)
                    && (cur_floor == sel_oh);
        push      = sel_vld && !pending_q[sel_idx] && !here_drop;
        pop       = (state_q == S_DISPATCH);
        arrive    = (state_q == S_TRAVEL) && !emergency_stop
                    && (cur_floor == target_q);
        pending_d = pending_q | (push ? sel_oh : 4'b0000);
        pending_d = pending_d & ~(arrive ? target_q : 4'b0000);
        count_d   = count_q + {2'b00, push} - {2'b00, pop};
    end

    // Request FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            latch_q   <= '0;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_q] <= sel_idx;
                wr_q         <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            latch_q   <= latch_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    // Dispatch / travel / dwell / halt sequencing with registered target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ret_q    <= S_IDLE;
            target_q <= '0;
            dwell_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    target_q <= '0;
                    if (count_q != 3'd0) state_q <= S_DISPATCH;
                end
                S_DISPATCH: begin
                    target_q <= 4'b0001 << fifo_q[rd_q];
                    state_q  <= S_TRAVEL;
                end
                S_TRAVEL: begin
                    if (emergency_stop) begin
                        ret_q   <= S_TRAVEL;
                        state_q <= S_HALT;
                    end else if (arrive) begin
                        dwell_q <= HOLD_LOAD;
                        state_q <= S_ARRIVED;
                    end
                end
                S_ARRIVED: begin
                    if (emergency_stop) begin
                        ret_q   <= S_ARRIVED;
                        state_q <= S_HALT;
                    end else if (dwell_q == '0) begin
                        if (count_q != 3'd0) begin
                            state_q <= S_DISPATCH;
                        end else begin
                            target_q <= '0;
                            state_q  <= S_IDLE;
                        end
                    end else begin
                        dwell_q <= dwell_q - 1'b1;
                    end
                end
                S_HALT: begin
                    if (!emergency_stop) state_q <= ret_q;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign target  = target_q;
    assign pending = pending_q;
    assign busy    = (state_q != S_IDLE);
    assign q_count = count_q;

endmodule

// File: tb/tb_floor_request_queue.sv
// Randomised and directed bench for floor_request_queue against a
// queue-based behavioural model of the request rules.
module tb_floor_request_queue;

    localparam int DB_COUNT    = 4;
    localparam int ARRIVE_HOLD = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = '0;
    logic [3:0] cur_floor = 4'b0001;
    logic       emergency_stop = 1'b0;
    logic [3:0] target, pending;
    logic       busy;
    logic [2:0] q_count;

    floor_request_queue #(
        .DB_COUNT(DB_COUNT), .DB_W(3),
        .ARRIVE_HOLD(ARRIVE_HOLD), .HOLD_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn),
        .cur_floor(cur_floor), .emergency_stop(emergency_stop),
        .target(target), .pending(pending),
        .busy(busy), .q_count(q_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // behavioural model
    typedef enum {M_IDLE, M_DISP, M_TRAV, M_ARR, M_HALT} mph_e;
    bit [3:0] m_s1, m_s2, m_lvl, m_latch, m_pend, m_tgt;
    int       m_run [4];
    int       q [$];
    mph_e     m_ph, m_ret;
    int       m_left;
    int       trav_cnt;

    function automatic void m_reset();
        m_s1 = 0; m_s2 = 0; m_lvl = 0; m_latch = 0;
        m_pend = 0; m_tgt = 0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        q.delete();
        m_ph = M_IDLE; m_ret = M_IDLE; m_left = 0; trav_cnt = 0;
    endfunction

    task automatic m_step();
        bit [3:0] prs;
        bit [3:0] av;
        int       sel;
        bit       do_push;
        int       osz;
        mph_e     oph;
        prs = 0; sel = -1; osz = q.size(); oph = m_ph;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == DB_COUNT) begin
                    m_lvl[i] = m_s2[i];
                    m_run[i] = 0;
                    if (m_s2[i]) prs[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = btn;
        av = m_latch | prs;
        for (int i = 0; i < 4; i++) if (av[i] && sel < 0) sel = i;
        if (sel >= 0) av[sel] = 1'b0;
        m_latch = av;
        do_push = (sel >= 0) && !m_pend[sel]
                  && !(oph == M_IDLE && osz == 0
                       && cur_floor == (4'b0001 << sel));
        case (oph)
            M_IDLE: begin
                m_tgt = 0;
                if (osz > 0) m_ph = M_DISP;
            end
            M_DISP: begin
                m_tgt = 4'b0001 << q.pop_front();
                m_ph = M_TRAV;
            end
            M_TRAV: begin
                if (emergency_stop) begin
                    m_ret = M_TRAV; m_ph = M_HALT;
                end else if (cur_floor == m_tgt) begin
                    m_ph = M_ARR;
                    m_left = ARRIVE_HOLD;
                    m_pend = m_pend & ~m_tgt;
                end
            end
            M_ARR: begin
                if (emergency_stop) begin
                    m_ret = M_ARR; m_ph = M_HALT;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (osz > 0) m_ph = M_DISP;
                        else begin m_ph = M_IDLE; m_tgt = 0; end
                    end
                end
            end
            M_HALT: if (!emergency_stop) m_ph = m_ret;
            default: ;
        endcase
        if (do_push) begin
            check("no_overflow", int'(osz < 4), 1);
            q.push_back(sel);
            m_pend[sel] = 1'b1;
        end
    endtask

    // 0: controller idle, 1: arrive after fixed delay, 2: random
    int       ctl_mode = 0;
    int       ctl_dly = 5;
    bit       seq_en = 0;
    logic [3:0] seq [$];
    logic [3:0] last_tgt = '0;
    int       max_q = 0;

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_step();
        @(negedge clk);
        check("target", target, m_tgt);
        check("pending", pending, m_pend);
        check("busy", busy, int'(m_ph != M_IDLE));
        check("q_count", q_count, q.size());
        if (seq_en && target != last_tgt && target != 0)
            seq.push_back(target);
        last_tgt = target;
        if (int'(q_count) > max_q) max_q = q_count;
        trav_cnt = (m_ph == M_TRAV) ? trav_cnt + 1 : 0;
        if (ctl_mode == 1) begin
            if (m_ph == M_TRAV && trav_cnt >= ctl_dly) cur_floor = m_tgt;
        end else if (ctl_mode == 2) begin
            if (m_ph == M_TRAV && trav_cnt >= ctl_dly) begin
                cur_floor = m_tgt;
                ctl_dly = $urandom_range(1, 8);
            end else if ($urandom_range(0, 19) == 0) begin
                cur_floor = 4'($urandom_range(0, 15));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tgt"}, target, 0);
        check({tag, "_pend"}, pending, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_qc"}, q_count, 0);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (k < budget && (m_ph != M_IDLE || q.size() != 0)) begin
            tick();
            k++;
        end
        check("idle_timeout", busy, 0);
    endtask

    initial begin
        m_reset();
        #12;
        check_zero("por");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) tick();
        check_zero("idle20");

        // debounce: chatter on button 3 then steady high
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) btn[2] = ~btn[2];
            tick();
        end
        btn[2] = 1'b1;
        repeat (12) tick();
        check("db_target", target, 4'b0100);
        check("db_pending", pending, 4'b0100);
        btn = '0;
        ctl_mode = 1;
        wait_idle(200);

        // FIFO order 3, 4, 2
        ctl_mode = 0;
        cur_floor = 4'b0001;
        seq.delete();
        seq_en = 1;
        btn[2] = 1'b1; tick();
        btn[3] = 1'b1; tick();
        btn[1] = 1'b1;
        repeat (8) tick();
        btn = '0;
        ctl_mode = 1;
        wait_idle(300);
        seq_en = 0;
        check("order_len", seq.size(), 3);
        if (seq.size() == 3) begin
            check("order0", seq[0], 4'b0100);
            check("order1", seq[1], 4'b1000);
            check("order2", seq[2], 4'b0010);
        end

        // simultaneous presses while a trip is in progress
        ctl_mode = 0;
        cur_floor = 4'b0010;
        btn[0] = 1'b1;
        repeat (8) tick();
        btn = '0;
        repeat (4) tick();
        max_q = 0;
        btn = 4'b1110;
        repeat (10) tick();
        btn = '0;
        repeat (6) tick();
        check("simul_peak", max_q, 3);
        btn[2] = 1'b1;
        repeat (8) tick();
        btn = '0;
        repeat (4) tick();
        check("dup_qc", q_count, 3);
        ctl_mode = 1;
        wait_idle(400);

        // emergency stop during travel toward floor 4
        ctl_mode = 0;
        cur_floor = 4'b0001;
        btn[3] = 1'b1;
        repeat (8) tick();
        btn = '0;
        for (int k = 0; k < 40 && m_ph != M_TRAV; k++) tick();
        emergency_stop = 1'b1;
        cur_floor = 4'b1000;
        repeat (5) tick();
        check("halt_tgt", target, 4'b1000);
        check("halt_pend3", pending[3], 1);
        check("halt_busy", busy, 1);
        emergency_stop = 1'b0;
        repeat (8) tick();
        wait_idle(100);

        // already at floor 1
        cur_floor = 4'b0001;
        btn[0] = 1'b1;
        repeat (10) tick();
        btn = '0;
        repeat (4) tick();
        check_zero("here");

        // randomised traffic with a mid-run reset
        ctl_mode = 2;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
            if ($urandom_range(0, 149) == 0) emergency_stop = ~emergency_stop;
            if (c == 2000) begin
                rst_n = 1'b0;
                #1;
                check_zero("mid_rst");
                m_reset();
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
            tick();
        end
        emergency_stop = 1'b0;
        btn = '0;
        wait_idle(600);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
